// File: rtl/dbg_pkg.sv
// Shared definitions for the debug read arbiter: FSM encoding, default
// timeout and the round-robin winner selection.
package dbg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } dbg_state_t;

    localparam int unsigned TIMEOUT_DEFAULT = 16;

    // Winner index for the two requesters. A sole requester always wins.
    // With both requesting, the one not served last wins. Until the first
    // completion there is no "last served", so requester 0 is preferred.
    function automatic logic rr_pick(
        input logic req0,
        input logic req1,
        input logic served_any,
        input logic last
    );
        if (req0 && req1) begin
            return served_any ? ~last : 1'b0;
        end
        return req1 && !req0;
    endfunction

endpackage

// File: rtl/dbg_rd_wdog.sv
// Bus watchdog: counts cycles spent waiting for an acknowledge and flags
// the cycle on which the wait limit is reached.
module dbg_rd_wdog #(
    parameter int unsigned TIMEOUT = dbg_pkg::TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expire
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    // Count waiting cycles; cleared whenever no bus access is outstanding.
    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            cnt <= '0;
        end else if (run && (cnt != CW'(TIMEOUT))) begin
            cnt <= cnt + CW'(1);
        end
    end

    // cnt holds the number of earlier waiting cycles, so the limit is hit
    // while the counter still reads TIMEOUT-1.
    assign expire = run && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/dbg_rd_arbiter.sv
// Two-requester round-robin arbiter in front of a single bus read port,
// with a per-access acknowledge timeout and target-reset abort.
module dbg_rd_arbiter
    import dbg_pkg::*;
#(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_cpu_reset,
    input  logic          i_req0,
    input  logic          i_req1,
    input  logic [AW-1:0] i_adr0,
    input  logic [AW-1:0] i_adr1,
    output logic          o_done0,
    output logic          o_done1,
    output logic [DW-1:0] o_rdata,
    output logic          o_err,
    output logic          o_grant,
    output logic          o_busy,
    output logic          o_wb_cyc,
    output logic [AW-1:0] o_wb_adr,
    input  logic          i_wb_ack,
    input  logic [DW-1:0] i_wb_rdt
);

    dbg_state_t state;
    logic       rr_last;
    logic       rr_served;
    logic       win;
    logic       expire;

    dbg_rd_wdog #(
        .TIMEOUT(TIMEOUT)
    ) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (state != BUS),
        .run    (state == BUS),
        .expire (expire)
    );

    // Requester that would be granted if arbitration happened this cycle.
    always_comb begin
        win = rr_pick(i_req0, i_req1, rr_served, rr_last);
    end

    // Arbitration FSM with registered bus and completion outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            rr_last   <= 1'b0;
            rr_served <= 1'b0;
            o_done0   <= 1'b0;
            o_done1   <= 1'b0;
            o_rdata   <= '0;
            o_err     <= 1'b0;
            o_grant   <= 1'b0;
            o_busy    <= 1'b0;
            o_wb_cyc  <= 1'b0;
            o_wb_adr  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_cpu_reset && (i_req0 || i_req1)) begin
                        o_grant  <= win;
                        o_wb_adr <= win ? i_adr1 : i_adr0;
                        o_wb_cyc <= 1'b1;
                        o_busy   <= 1'b1;
                        state    <= BUS;
                    end
                end
                BUS: begin
                    // Abort beats ack, and ack beats timeout.
                    if (!i_cpu_reset) begin
                        o_wb_cyc <= 1'b0;
                        o_busy   <= 1'b0;
                        state    <= IDLE;
                    end else if (i_wb_ack || expire) begin
                        o_rdata  <= i_wb_ack ? i_wb_rdt : '0;
                        o_err    <= !i_wb_ack;
                        o_wb_cyc <= 1'b0;
                        o_done0  <= !o_grant;
                        o_done1  <= o_grant;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    o_done0   <= 1'b0;
                    o_done1   <= 1'b0;
                    o_busy    <= 1'b0;
                    rr_last   <= o_grant;
                    rr_served <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dbg_rd_arbiter.sv
// Directed bench for dbg_rd_arbiter: single read, contention, timeout,
// ack on the last allowed cycle, abort, reset mid-access and stray ack.
module tb_dbg_rd_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_cpu_reset;
    logic          i_req0;
    logic          i_req1;
    logic [AW-1:0] i_adr0;
    logic [AW-1:0] i_adr1;
    logic          o_done0;
    logic          o_done1;
    logic [DW-1:0] o_rdata;
    logic          o_err;
    logic          o_grant;
    logic          o_busy;
    logic          o_wb_cyc;
    logic [AW-1:0] o_wb_adr;
    logic          i_wb_ack;
    logic [DW-1:0] i_wb_rdt;

    int unsigned n_chk = 0;
    int unsigned n_err = 0;
    int unsigned n_done0 = 0;
    int unsigned n_done1 = 0;

    dbg_rd_arbiter #(
        .AW      (AW),
        .DW      (DW),
        .TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_cpu_reset (i_cpu_reset),
        .i_req0      (i_req0),
        .i_req1      (i_req1),
        .i_adr0      (i_adr0),
        .i_adr1      (i_adr1),
        .o_done0     (o_done0),
        .o_done1     (o_done1),
        .o_rdata     (o_rdata),
        .o_err       (o_err),
        .o_grant     (o_grant),
        .o_busy      (o_busy),
        .o_wb_cyc    (o_wb_cyc),
        .o_wb_adr    (o_wb_adr),
        .i_wb_ack    (i_wb_ack),
        .i_wb_rdt    (i_wb_rdt)
    );

    always #5 clk = ~clk;

    // Count every cycle in which a completion pulse is high.
    always @(posedge clk) begin
        if (o_done0) n_done0 <= n_done0 + 1;
        if (o_done1) n_done1 <= n_done1 + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " cyc"},   64'(o_wb_cyc), 64'd0);
        chk({tag, " busy"},  64'(o_busy),   64'd0);
        chk({tag, " done0"}, 64'(o_done0),  64'd0);
        chk({tag, " done1"}, 64'(o_done1),  64'd0);
        chk({tag, " grant"}, 64'(o_grant),  64'd0);
        chk({tag, " adr"},   64'(o_wb_adr), 64'd0);
        chk({tag, " rdata"}, 64'(o_rdata),  64'd0);
        chk({tag, " err"},   64'(o_err),    64'd0);
    endtask

    initial begin
        logic [1:0] exp_grant [4];
        exp_grant = '{2'd0, 2'd1, 2'd0, 2'd1};

        rst = 1'b0; i_cpu_reset = 1'b1; i_req0 = 1'b0; i_req1 = 1'b0;
        i_adr0 = '0; i_adr1 = '0; i_wb_ack = 1'b0; i_wb_rdt = '0;
        tick(); tick();
        check_all_zero("reset");
        rst = 1'b1;

        // Single read from requester 0, acked on the third bus cycle.
        i_req0 = 1'b1; i_adr0 = 32'h100;
        tick();
        chk("single cyc",   64'(o_wb_cyc), 64'd1);
        chk("single busy",  64'(o_busy),   64'd1);
        chk("single adr",   64'(o_wb_adr), 64'h100);
        chk("single grant", 64'(o_grant),  64'd0);
        i_adr0 = 32'h200;
        tick();
        chk("single adr held", 64'(o_wb_adr), 64'h100);
        tick();
        i_wb_ack = 1'b1; i_wb_rdt = 32'hDEADBEEF;
        tick();
        chk("single done0", 64'(o_done0), 64'd1);
        chk("single rdata", 64'(o_rdata), 64'hDEADBEEF);
        chk("single err",   64'(o_err),   64'd0);
        chk("single cyc off",   64'(o_wb_cyc), 64'd0);
        chk("single busy done", 64'(o_busy),   64'd1);
        i_req0 = 1'b0; i_wb_ack = 1'b0;
        tick();
        chk("single done0 off", 64'(o_done0), 64'd0);
        chk("single busy off",  64'(o_busy),  64'd0);

        // Fresh reset so requester 0 has priority again.
        rst = 1'b0;
        tick();
        rst = 1'b1;

        // Contention with immediate acks.
        i_req0 = 1'b1; i_req1 = 1'b1; i_adr0 = 32'h10; i_adr1 = 32'h20;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rr grant", 64'(o_grant),  64'(exp_grant[i]));
            chk("rr adr",   64'(o_wb_adr), exp_grant[i][0] ? 64'h20 : 64'h10);
            i_wb_ack = 1'b1; i_wb_rdt = 32'(i + 1);
            tick();
            chk("rr done",  64'({o_done1, o_done0}), exp_grant[i][0] ? 64'd2 : 64'd1);
            chk("rr rdata", 64'(o_rdata), 64'(i + 1));
            i_wb_ack = 1'b0;
            tick();
            chk("rr idle busy", 64'(o_busy), 64'd0);
        end
        i_req0 = 1'b0; i_req1 = 1'b0;
        tick();

        // Timeout on requester 1.
        i_req1 = 1'b1; i_adr1 = 32'h300;
        tick();
        for (int i = 0; i < 15; i++) tick();
        chk("to cyc at 16",   64'(o_wb_cyc), 64'd1);
        chk("to done1 early", 64'(o_done1),  64'd0);
        tick();
        chk("to done1", 64'(o_done1),  64'd1);
        chk("to err",   64'(o_err),    64'd1);
        chk("to rdata", 64'(o_rdata),  64'd0);
        chk("to cyc",   64'(o_wb_cyc), 64'd0);
        i_req1 = 1'b0;
        tick();

        // Ack arriving on the final allowed cycle completes without error.
        i_req0 = 1'b1; i_adr0 = 32'h400;
        tick();
        for (int i = 0; i < 15; i++) tick();
        i_wb_ack = 1'b1; i_wb_rdt = 32'h0000CAFE;
        tick();
        chk("ack16 done0", 64'(o_done0), 64'd1);
        chk("ack16 err",   64'(o_err),   64'd0);
        chk("ack16 rdata", 64'(o_rdata), 64'hCAFE);
        i_req0 = 1'b0; i_wb_ack = 1'b0;
        tick(); tick();
        chk("hold rdata", 64'(o_rdata), 64'hCAFE);
        chk("hold err",   64'(o_err),   64'd0);

        // Abort on the second bus cycle while ack is also high.
        i_req1 = 1'b1; i_adr1 = 32'h40;
        tick();
        tick();
        i_cpu_reset = 1'b0; i_wb_ack = 1'b1; i_wb_rdt = 32'h99;
        tick();
        chk("abort cyc",   64'(o_wb_cyc), 64'd0);
        chk("abort busy",  64'(o_busy),   64'd0);
        chk("abort done",  64'({o_done1, o_done0}), 64'd0);
        chk("abort rdata", 64'(o_rdata),  64'hCAFE);
        i_req1 = 1'b0; i_wb_ack = 1'b0; i_req0 = 1'b1;
        tick();
        chk("held reset ignores req", 64'(o_wb_cyc), 64'd0);
        // Pointer still says requester 0 was last served, so 1 must win.
        i_cpu_reset = 1'b1; i_req1 = 1'b1;
        tick();
        chk("post abort grant", 64'(o_grant),  64'd1);
        chk("post abort adr",   64'(o_wb_adr), 64'h40);
        i_wb_ack = 1'b1; i_wb_rdt = 32'h77;
        tick();
        chk("post abort done1", 64'(o_done1), 64'd1);
        chk("post abort rdata", 64'(o_rdata), 64'h77);
        i_wb_ack = 1'b0; i_req0 = 1'b0; i_req1 = 1'b0;
        tick();

        // Reset during a bus access.
        i_req0 = 1'b1; i_adr0 = 32'h55;
        tick();
        chk("pre rst cyc", 64'(o_wb_cyc), 64'd1);
        rst = 1'b0;
        tick();
        check_all_zero("rst in bus");
        rst = 1'b1; i_req0 = 1'b0;

        // Stray ack while idle.
        i_wb_ack = 1'b1; i_wb_rdt = 32'h1234;
        tick(); tick();
        check_all_zero("stray ack");
        i_wb_ack = 1'b0;
        tick();

        chk("done0 pulses", 64'(n_done0), 64'd4);
        chk("done1 pulses", 64'(n_done1), 64'd4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
